// File: rtl/verinject_pkg.sv
// Shared constants and types for the verinject fault-injection harness.
// Used by the injection sequencer and its schedule table.
package verinject_pkg;

  localparam logic [31:0] VERINJECT_IDLE_INDEX = 32'hFFFF_FFFF;
  localparam logic [31:0] VERINJECT_LFSR_POLY  = 32'h8020_0003;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  // One step of the right-shifting Galois LFSR used for random injection runs.
  function automatic logic [31:0] verinject_lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ VERINJECT_LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/verinject_seq_table.sv
// Schedule register file: DEPTH entries of (relative cycle, bit index),
// written synchronously by the host and read combinationally by the sequencer.
module verinject_seq_table #(
  parameter int DEPTH      = 16,
  parameter int DEPTH_LOG2 = 4,
  parameter int CYCLE_W    = 32
) (
  input  logic                  clock,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [CYCLE_W-1:0]    i_cycle,
  input  logic [31:0]           i_index,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [CYCLE_W-1:0]    o_cycle,
  output logic [31:0]           o_index
);

  logic [CYCLE_W-1:0] r_cycle [DEPTH];
  logic [31:0]        r_index [DEPTH];

  // NOTE: storage arrays carry no reset; the host always programs entries before a run reads them.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_cycle[i_waddr] <= i_cycle;
      r_index[i_waddr] <= i_index;
    end
  end

  assign o_cycle = r_cycle[i_raddr];
  assign o_index = r_index[i_raddr];

endmodule

// File: rtl/verinject_injection_sequencer.sv
// Replays a host-programmed (cycle, bit index) schedule onto verinject__injector_state.
// Optional feature macro: VERINJECT_SEQ_RANDOM_EN adds an LFSR-driven random mode.
module verinject_injection_sequencer
  import verinject_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DEPTH_LOG2 = 4,
  parameter int CYCLE_W    = 32
`ifdef VERINJECT_SEQ_RANDOM_EN
  ,
  parameter int          RAND_LIMIT = 1024,
  parameter logic [31:0] SEED       = 32'h1
`endif
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cfg_we,
  input  logic [DEPTH_LOG2-1:0] cfg_addr,
  input  logic [CYCLE_W-1:0]    cfg_cycle,
  input  logic [31:0]           cfg_index,
  input  logic [DEPTH_LOG2:0]   cfg_count,
  input  logic                  start,
  input  logic                  abort,
`ifdef VERINJECT_SEQ_RANDOM_EN
  input  logic                  rand_mode,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   injected_count,
  output logic [DEPTH_LOG2:0]   late_count,
  output logic [31:0]           verinject__injector_state
);

  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  seq_state_e            r_state;
  logic [DEPTH_LOG2-1:0] r_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [CYCLE_W-1:0]    r_counter;
  logic [CNT_W-1:0]      r_injected;
  logic [CNT_W-1:0]      r_late;
  logic [31:0]           r_word;

  logic                  w_we;
  logic [CYCLE_W-1:0]    w_rd_cycle;
  logic [31:0]           w_rd_index;
  logic [CNT_W-1:0]      w_start_count;
  logic [CYCLE_W-1:0]    w_counter_next;
  logic                  w_due;
  logic                  w_late;
  logic                  w_last;
  logic                  w_emit;
  logic                  w_emit_late;
  logic [31:0]           w_emit_index;

  // The table is frozen while a run is reading it.
  assign w_we = cfg_we && (r_state != SEQ_RUN);

  verinject_seq_table #(
    .DEPTH      (DEPTH),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .CYCLE_W    (CYCLE_W)
  ) u_table (
    .clock   (clock),
    .i_we    (w_we),
    .i_waddr (cfg_addr),
    .i_cycle (cfg_cycle),
    .i_index (cfg_index),
    .i_raddr (r_ptr),
    .o_cycle (w_rd_cycle),
    .o_index (w_rd_index)
  );

  assign w_start_count  = (cfg_count > DEPTH_CNT) ? DEPTH_CNT : cfg_count;
  assign w_counter_next = (&r_counter) ? r_counter : r_counter + CYCLE_W'(1);
  assign w_due          = (r_counter >= w_rd_cycle);
  assign w_late         = (r_counter > w_rd_cycle);
  assign w_last         = (({1'b0, r_ptr} + CNT_W'(1)) == r_count);

`ifdef VERINJECT_SEQ_RANDOM_EN
  logic        r_rand;
  logic [31:0] r_lfsr;

  // Random mode emits one LFSR-derived index every RUN cycle, never late.
  assign w_emit       = r_rand || w_due;
  assign w_emit_index = r_rand ? (r_lfsr % 32'(RAND_LIMIT)) : w_rd_index;
  assign w_emit_late  = !r_rand && w_late;
`else
  assign w_emit       = w_due;
  assign w_emit_index = w_rd_index;
  assign w_emit_late  = w_late;
`endif

  // NOTE: all state below updates with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= SEQ_IDLE;
      r_ptr      <= '0;
      r_count    <= '0;
      r_counter  <= '0;
      r_injected <= '0;
      r_late     <= '0;
      r_word     <= VERINJECT_IDLE_INDEX;
`ifdef VERINJECT_SEQ_RANDOM_EN
      r_rand     <= 1'b0;
      r_lfsr     <= SEED;
`endif
    end else if (abort) begin
      r_state <= SEQ_IDLE;
      r_word  <= VERINJECT_IDLE_INDEX;
    end else begin
      case (r_state)
        SEQ_IDLE, SEQ_DONE: begin
          r_word <= VERINJECT_IDLE_INDEX;
          if (start) begin
            r_ptr      <= '0;
            r_counter  <= '0;
            r_injected <= '0;
            r_late     <= '0;
            r_count    <= w_start_count;
            r_state    <= (cfg_count != '0) ? SEQ_RUN : SEQ_DONE;
`ifdef VERINJECT_SEQ_RANDOM_EN
            r_rand     <= rand_mode;
            r_lfsr     <= SEED;
`endif
          end
        end
        SEQ_RUN: begin
          r_counter <= w_counter_next;
`ifdef VERINJECT_SEQ_RANDOM_EN
          r_lfsr    <= verinject_lfsr_step(r_lfsr);
`endif
          if (w_emit) begin
            r_word <= w_emit_index;
            r_ptr  <= r_ptr + DEPTH_LOG2'(1);
            if (w_emit_index != VERINJECT_IDLE_INDEX) r_injected <= r_injected + CNT_W'(1);
            if (w_emit_late) r_late <= r_late + CNT_W'(1);
            if (w_last) r_state <= SEQ_DONE;
          end else begin
            r_word <= VERINJECT_IDLE_INDEX;
          end
        end
        default: begin
          r_state <= SEQ_IDLE;
          r_word  <= VERINJECT_IDLE_INDEX;
        end
      endcase
    end
  end

  assign busy                      = (r_state == SEQ_RUN);
  assign done                      = (r_state == SEQ_DONE);
  assign injected_count            = r_injected;
  assign late_count                = r_late;
  assign verinject__injector_state = r_word;

endmodule

// File: tb/tb_verinject_injection_sequencer.sv
// Scoreboard bench for verinject_injection_sequencer: a schedule-level model predicts
// each emission (time, index); a negedge monitor pops and compares.
module tb_verinject_injection_sequencer;

  localparam int DEPTH      = 16;
  localparam int DEPTH_LOG2 = 4;
  localparam int CYCLE_W    = 32;
  localparam logic [31:0] IDLE_W = 32'hFFFF_FFFF;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic                  cfg_we;
  logic [DEPTH_LOG2-1:0] cfg_addr;
  logic [CYCLE_W-1:0]    cfg_cycle;
  logic [31:0]           cfg_index;
  logic [DEPTH_LOG2:0]   cfg_count;
  logic                  start;
  logic                  abort;
`ifdef VERINJECT_SEQ_RANDOM_EN
  logic                  rand_mode;
`endif
  logic                  busy;
  logic                  done;
  logic [DEPTH_LOG2:0]   injected_count;
  logic [DEPTH_LOG2:0]   late_count;
  logic [31:0]           verinject__injector_state;

  verinject_injection_sequencer #(
    .DEPTH      (DEPTH),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .CYCLE_W    (CYCLE_W)
  ) dut (
    .clock                     (clock),
    .reset_n                   (reset_n),
    .cfg_we                    (cfg_we),
    .cfg_addr                  (cfg_addr),
    .cfg_cycle                 (cfg_cycle),
    .cfg_index                 (cfg_index),
    .cfg_count                 (cfg_count),
    .start                     (start),
    .abort                     (abort),
`ifdef VERINJECT_SEQ_RANDOM_EN
    .rand_mode                 (rand_mode),
`endif
    .busy                      (busy),
    .done                      (done),
    .injected_count            (injected_count),
    .late_count                (late_count),
    .verinject__injector_state (verinject__injector_state)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    int          t;
    logic [31:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Bench copy of what has been committed to the schedule table.
  int          m_cyc [DEPTH];
  logic [31:0] m_idx [DEPTH];
  int          exp_inj;
  int          exp_late;
  int          exp_done_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  exp_t mon_e;
  always @(negedge clock) begin
    if (reset_n === 1'b1 && verinject__injector_state !== IDLE_W) begin
      if (exp_q.size() == 0) begin
        check("unexpected_emit", verinject__injector_state, IDLE_W);
      end else begin
        mon_e = exp_q.pop_front();
        check("emit_index", verinject__injector_state, mon_e.idx);
        check("emit_time", cyc, mon_e.t);
      end
    end
  end

  // Emission times follow from the schedule alone: each entry leaves at the later of
  // its own cycle and one cycle after its predecessor, and is visible one cycle after that.
  task automatic model_run(input int n_cfg, input int stop_t, input int base);
    int n, t_prev, te;
    n = (n_cfg > DEPTH) ? DEPTH : n_cfg;
    exp_inj  = 0;
    exp_late = 0;
    t_prev   = -1;
    for (int i = 0; i < n; i++) begin
      te = (m_cyc[i] > t_prev + 1) ? m_cyc[i] : t_prev + 1;
      if (stop_t < 0 || te < stop_t) begin
        if (m_idx[i] != IDLE_W) begin
          exp_q.push_back('{base + te + 1, m_idx[i]});
          exp_inj++;
        end
        if (te > m_cyc[i]) exp_late++;
      end
      t_prev = te;
    end
    exp_done_t = (n == 0) ? 0 : t_prev + 1;
  endtask

  task automatic write_entry(input int a, input int c, input logic [31:0] idx);
    cfg_we    = 1'b1;
    cfg_addr  = a[DEPTH_LOG2-1:0];
    cfg_cycle = CYCLE_W'(c);
    cfg_index = idx;
    @(posedge clock); #1;
    cfg_we = 1'b0;
    m_cyc[a] = c;
    m_idx[a] = idx;
  endtask

  // stop_t >= 0 interrupts the run at that T with abort (or reset when use_reset).
  task automatic run(input int n_cfg, input int stop_t, input bit use_reset, input bit we_in_run);
    int t, base;
    bit finished;
    cfg_count = n_cfg[DEPTH_LOG2:0];
    start = 1'b1;
    @(posedge clock); #1;
    start  = 1'b0;
    cfg_we = 1'b0;
    base   = cyc;
    model_run(n_cfg, stop_t, base);
    if (n_cfg != 0) check("busy_at_t0", 32'(busy), 32'd1);
    t = 0;
    finished = 1'b0;
    while (!finished && t < 300) begin
      if (t == stop_t) begin
        if (use_reset) reset_n = 1'b0;
        else abort = 1'b1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        abort   = 1'b0;
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_done", 32'(done), 32'd0);
        check("stop_word", verinject__injector_state, IDLE_W);
        check("stop_injected", 32'(injected_count), use_reset ? 32'd0 : exp_inj);
        check("stop_late", 32'(late_count), use_reset ? 32'd0 : exp_late);
        finished = 1'b1;
      end else if (done === 1'b1) begin
        check("done_time", t, exp_done_t);
        check("busy_in_done", 32'(busy), 32'd0);
        check("injected_count", 32'(injected_count), exp_inj);
        check("late_count", 32'(late_count), exp_late);
        @(posedge clock); #1;
        check("idle_after_done", verinject__injector_state, IDLE_W);
        finished = 1'b1;
      end else begin
        if (we_in_run && t == 1) begin
          cfg_we    = 1'b1;
          cfg_addr  = 1;
          cfg_cycle = 7;
          cfg_index = 32'd99;
        end
        @(posedge clock); #1;
        cfg_we = 1'b0;
        t++;
      end
    end
    if (!finished) check("run_timeout", 32'd0, 32'd1);
    check("scoreboard_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    int c, n_cfg, stop;
    reset_n   = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_cycle = '0;
    cfg_index = '0;
    cfg_count = '0;
    start     = 1'b0;
    abort     = 1'b0;
`ifdef VERINJECT_SEQ_RANDOM_EN
    rand_mode = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_injected", 32'(injected_count), 32'd0);
    check("reset_late", 32'(late_count), 32'd0);
    check("reset_word", verinject__injector_state, IDLE_W);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Two on-time entries.
    write_entry(0, 3, 32'd40);
    write_entry(1, 7, 32'd41);
    run(2, -1, 1'b0, 1'b0);

    // Equal and out-of-order cycles become late back-to-back emissions.
    write_entry(0, 5, 32'd9);
    write_entry(1, 5, 32'd10);
    write_entry(2, 2, 32'd11);
    run(3, -1, 1'b0, 1'b0);

    // No-op entry, with the second entry written on the start edge itself.
    write_entry(0, 0, IDLE_W);
    cfg_we    = 1'b1;
    cfg_addr  = 1;
    cfg_cycle = 1;
    cfg_index = 32'd3;
    m_cyc[1]  = 1;
    m_idx[1]  = 32'd3;
    run(2, -1, 1'b0, 1'b0);

    // Abort at T=4 with a write attempted mid-run; then rerun to see the table intact.
    write_entry(0, 3, 32'd40);
    write_entry(1, 7, 32'd41);
    run(2, 4, 1'b0, 1'b1);
    run(2, -1, 1'b0, 1'b0);

    // Empty schedule, then reset during a run.
    run(0, -1, 1'b0, 1'b0);
    run(2, 5, 1'b1, 1'b0);

    // Randomised schedules, including counts above DEPTH and one aborted run.
    for (int r = 0; r < 6; r++) begin
      c = int'($urandom_range(0, 3));
      for (int i = 0; i < DEPTH; i++) begin
        if ($urandom_range(0, 7) == 0) c = c - int'($urandom_range(0, c));
        else if (i != 0) c = c + int'($urandom_range(0, 4));
        write_entry(i, c, ($urandom_range(0, 7) == 0) ? IDLE_W : $urandom);
      end
      n_cfg = int'($urandom_range(1, 20));
      stop  = (r == 5) ? int'($urandom_range(1, 20)) : -1;
      run(n_cfg, stop, 1'b0, 1'b0);
    end

`ifdef VERINJECT_SEQ_RANDOM_EN
    begin
      logic [31:0] v;
      int base, t;
      rand_mode = 1'b1;
      cfg_count = 5'd4;
      start     = 1'b1;
      @(posedge clock); #1;
      start     = 1'b0;
      rand_mode = 1'b0;
      base      = cyc;
      v = 32'h1;
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back('{base + i + 1, v % 32'd1024});
        v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
      end
      t = 0;
      while (done !== 1'b1 && t < 50) begin
        @(posedge clock); #1;
        t++;
      end
      check("rand_done_time", t, 32'd4);
      check("rand_injected", 32'(injected_count), 32'd4);
      check("rand_late", 32'(late_count), 32'd0);
      @(posedge clock); #1;
      check("rand_drained", exp_q.size(), 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
